// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for seq_alu and its iterative datapath.
//   DATA_W       - operand/result width
//   MULDIV_ITERS - number of MUL/DIV iterations (equals DATA_W)
//   CNT_W        - width of the iteration counter
//   op_e         - operation encoding carried on the 3-bit op field
//   state_e      - control state (IDLE / ITER)
//   alu_basic()  - single-cycle result with carry/borrow in the top bit
package alu_pkg;

  localparam int DATA_W       = 16;
  localparam int MULDIV_ITERS = 16;
  localparam int CNT_W        = $clog2(MULDIV_ITERS) + 1;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_PASSB = 3'd5,
    OP_MUL   = 3'd6,
    OP_DIV   = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_e;

  // Returns {carry, result}. SUB borrow falls out of the 17-bit
  // subtraction wrapping when a < b. MUL/DIV fall back to PASSB here.
  function automatic logic [DATA_W:0] alu_basic(input op_e op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (op)
      OP_ADD:   r = {1'b0, a} + {1'b0, b};
      OP_SUB:   r = {1'b0, a} - {1'b0, b};
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_PASSB: r = {1'b0, b};
      default:  r = {1'b0, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the control unit and seq_alu.
//   start, op, a, b                   - request (driven by master)
//   alu_out, done, busy, zero, carry  - result/status (driven by slave)
interface seq_alu_if;
  import alu_pkg::*;

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_out;
  logic              done;
  logic              busy;
  logic              zero;
  logic              carry;

  modport master (output start, op, a, b,
                  input  alu_out, done, busy, zero, carry);

  modport slave  (input  start, op, a, b,
                  output alu_out, done, busy, zero, carry);

endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// muldiv_iter: iterative unsigned multiply (shift-add, multiplier LSB
// first) and restoring divide (quotient MSB first), one bit per step.
//   clk, rst - clock, synchronous active-high reset
//   load     - latch operands, clear partial product and counter
//   step     - perform one iteration
//   is_div   - sampled with load: 1 = divide, 0 = multiply
//   a, b     - operands (multiplicand/multiplier or dividend/divisor)
//   last     - current step is the final iteration
//   result   - value the datapath will hold after the current step
module muldiv_iter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] result
);

  logic                div_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W-1:0] prod_r;
  logic [2*DATA_W-1:0] mcand_r;
  // Multiplier for MUL; dividend shifting out / quotient shifting in for DIV.
  logic [DATA_W-1:0]   shift_r;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   dvsr_r;

  logic [2*DATA_W-1:0] prod_next_s;
  logic [DATA_W:0]     rem_shift_s;
  logic [DATA_W:0]     diff_s;
  logic [DATA_W-1:0]   quo_next_s;
  logic [DATA_W-1:0]   rem_next_s;

  assign last = (cnt_r == CNT_W'(MULDIV_ITERS - 1));

  // One iteration of each algorithm; a negative trial difference restores.
  always_comb begin
    prod_next_s = prod_r;
    if (shift_r[0]) begin
      prod_next_s = prod_r + mcand_r;
    end else begin
      prod_next_s = prod_r;
    end
    rem_shift_s = {rem_r, shift_r[DATA_W-1]};
    diff_s      = rem_shift_s - {1'b0, dvsr_r};
    quo_next_s  = {shift_r[DATA_W-2:0], ~diff_s[DATA_W]};
    if (diff_s[DATA_W]) begin
      rem_next_s = rem_shift_s[DATA_W-1:0];
    end else begin
      rem_next_s = diff_s[DATA_W-1:0];
    end
    if (div_r) begin
      result = quo_next_s;
    end else begin
      result = prod_next_s[DATA_W-1:0];
    end
  end

  // Operand latch on load, then one shift/add or shift/subtract per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      prod_r  <= {(2*DATA_W){1'b0}};
      mcand_r <= {(2*DATA_W){1'b0}};
      shift_r <= {DATA_W{1'b0}};
      rem_r   <= {DATA_W{1'b0}};
      dvsr_r  <= {DATA_W{1'b0}};
    end else if (load) begin
      div_r   <= is_div;
      cnt_r   <= {CNT_W{1'b0}};
      prod_r  <= {(2*DATA_W){1'b0}};
      mcand_r <= {{DATA_W{1'b0}}, a};
      shift_r <= is_div ? a : b;
      rem_r   <= {DATA_W{1'b0}};
      dvsr_r  <= b;
    end else if (step) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (div_r) begin
        shift_r <= quo_next_s;
        rem_r   <= rem_next_s;
      end else begin
        prod_r  <= prod_next_s;
        mcand_r <= {mcand_r[2*DATA_W-2:0], 1'b0};
        shift_r <= {1'b0, shift_r[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU feeding the accumulator. ADD/SUB/AND/OR/XOR/
// PASSB complete in one cycle; MUL/DIV iterate for 16 cycles.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - seq_alu_if.slave: start/op/a/b in, alu_out/done/busy/zero/carry out
// Build option: define SEQ_ALU_MULDIV_EN to include the iterative MUL/DIV
// datapath. Without it, busy is tied low and MUL/DIV act as PASSB.
module seq_alu
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  state_e            state_r;
  state_e            state_next_s;
  op_e               op_s;
  logic              accept_s;
  logic              single_s;
  logic              fin_s;
  logic              is_muldiv_s;
  logic              md_last_s;
  logic [DATA_W-1:0] md_res_s;
  logic [DATA_W:0]   basic_s;

  logic [DATA_W-1:0] alu_out_r;
  logic              done_r;
  logic              busy_r;
  logic              zero_r;
  logic              carry_r;

  assign op_s     = op_e'(bus.op);
  assign accept_s = bus.start && (state_r == IDLE);
  assign single_s = accept_s && !is_muldiv_s;

`ifdef SEQ_ALU_MULDIV_EN
  logic div_by_zero_s;

  // Divide by zero skips iteration and completes like a single-cycle op.
  assign div_by_zero_s = (op_s == OP_DIV) && (bus.b == {DATA_W{1'b0}});
  assign is_muldiv_s   = ((op_s == OP_MUL) || (op_s == OP_DIV)) && !div_by_zero_s;

  muldiv_iter u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_s && is_muldiv_s),
    .step   (state_r == ITER),
    .is_div (op_s == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .last   (md_last_s),
    .result (md_res_s)
  );

  // Single-cycle result, with the all-ones quotient for divide by zero.
  always_comb begin
    basic_s = alu_basic(op_s, bus.a, bus.b);
    if (div_by_zero_s) begin
      basic_s = {1'b0, {DATA_W{1'b1}}};
    end else begin
      basic_s = alu_basic(op_s, bus.a, bus.b);
    end
  end
`else
  assign is_muldiv_s = 1'b0;
  assign md_last_s   = 1'b0;
  assign md_res_s    = {DATA_W{1'b0}};
  assign basic_s     = alu_basic(op_s, bus.a, bus.b);
`endif

  // Next-state logic: IDLE -> ITER on an accepted MUL/DIV, back on the last step.
  always_comb begin
    state_next_s = state_r;
    fin_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && is_muldiv_s) begin
          state_next_s = ITER;
        end else begin
          state_next_s = IDLE;
        end
      end
      ITER: begin
        if (md_last_s) begin
          fin_s        = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = ITER;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered result and status; done pulses for exactly one cycle per result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_r <= {DATA_W{1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      zero_r    <= 1'b0;
      carry_r   <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ITER);
      if (single_s) begin
        alu_out_r <= basic_s[DATA_W-1:0];
        zero_r    <= (basic_s[DATA_W-1:0] == {DATA_W{1'b0}});
        carry_r   <= basic_s[DATA_W];
        done_r    <= 1'b1;
      end else if (fin_s) begin
        alu_out_r <= md_res_s;
        zero_r    <= (md_res_s == {DATA_W{1'b0}});
        carry_r   <= 1'b0;
        done_r    <= 1'b1;
      end else begin
        done_r    <= 1'b0;
      end
    end
  end

  assign bus.alu_out = alu_out_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.zero    = zero_r;
  assign bus.carry   = carry_r;

endmodule
